// File: rtl/instr_encoder_if.sv
// Request/instruction-memory bundle between an instruction source and instr_encoder.
// The slave modport is the encoder's view; master is the source/memory side.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op_class;
  logic [3:0]  alu_op;
  logic [2:0]  br_type;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        last;
  logic        imem_wr_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        done;
  logic        error;

  modport slave (
    input  in_valid, op_class, alu_op, br_type, rd, rs1, rs2, imm, last,
    output in_ready, imem_wr_en, imem_addr, imem_wdata, done, error
  );

  modport master (
    output in_valid, op_class, alu_op, br_type, rd, rs1, rs2, imm, last,
    input  in_ready, imem_wr_en, imem_addr, imem_wdata, done, error
  );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: accepts decoded instruction requests and writes
// encoded words to consecutive instruction-memory addresses, one word per 3 cycles.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          DEPTH     = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  instr_encoder_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ENCODE = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_ERR    = 3'd4;

  localparam logic [3:0] OP_R      = 4'd0;
  localparam logic [3:0] OP_I      = 4'd1;
  localparam logic [3:0] OP_LOAD   = 4'd2;
  localparam logic [3:0] OP_STORE  = 4'd3;
  localparam logic [3:0] OP_BRANCH = 4'd4;
  localparam logic [3:0] OP_LUI    = 4'd5;
  localparam logic [3:0] OP_AUIPC  = 4'd6;
  localparam logic [3:0] OP_JAL    = 4'd7;
  localparam logic [3:0] OP_JALR   = 4'd8;

  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  logic [2:0]    state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [3:0]    alu_q, alu_d;
  logic [2:0]    br_q, br_d;
  logic [4:0]    rd_q, rd_d;
  logic [4:0]    rs1_q, rs1_d;
  logic [4:0]    rs2_q, rs2_d;
  logic [31:0]   imm_q, imm_d;
  logic          last_q, last_d;
  logic          in_ready_q, in_ready_d;
  logic          wr_en_q, wr_en_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [CW-1:0] count_q, count_d;
  logic          legal_s;
  logic [31:0]   encoded_s;

  function automatic logic [2:0] alu_funct3(input logic [3:0] alu);
    logic [2:0] f3;
    case (alu)
      4'd0:    f3 = 3'b000;
      4'd1:    f3 = 3'b000;
      4'd2:    f3 = 3'b111;
      4'd3:    f3 = 3'b110;
      4'd4:    f3 = 3'b100;
      4'd5:    f3 = 3'b001;
      4'd6:    f3 = 3'b101;
      4'd7:    f3 = 3'b010;
      4'd8:    f3 = 3'b101;
      4'd9:    f3 = 3'b011;
      default: f3 = 3'b000;
    endcase
    return f3;
  endfunction

  function automatic logic is_legal(input logic [3:0] op, input logic [3:0] alu,
                                    input logic [2:0] br);
    logic ok;
    case (op)
      OP_R:      ok = (alu <= ALU_SLTU);
      OP_I:      ok = (alu <= ALU_SLTU) && (alu != ALU_SUB);
      OP_BRANCH: ok = (br != 3'b010) && (br != 3'b011);
      OP_LOAD, OP_STORE, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: ok = 1'b1;
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Fields not used by a format are simply left out of its concatenation, so they encode as 0.
  function automatic logic [31:0] encode_instr(
    input logic [3:0]  op,
    input logic [3:0]  alu,
    input logic [2:0]  br,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm
  );
    logic [31:0] w;
    logic [6:0]  f7;
    logic [2:0]  f3;
    f3 = alu_funct3(alu);
    f7 = ((alu == ALU_SUB) || (alu == ALU_SRA)) ? 7'b0100000 : 7'b0000000;
    case (op)
      OP_R:      w = {f7, rs2, rs1, f3, rd, 7'b0110011};
      OP_I: begin
        if ((alu == ALU_SLL) || (alu == ALU_SRL) || (alu == ALU_SRA)) begin
          w = {f7, imm[4:0], rs1, f3, rd, 7'b0010011};
        end else begin
          w = {imm[11:0], rs1, f3, rd, 7'b0010011};
        end
      end
      OP_LOAD:   w = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      OP_STORE:  w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      OP_BRANCH: w = {imm[12], imm[10:5], rs2, rs1, br, imm[4:1], imm[11], 7'b1100011};
      OP_LUI:    w = {imm[31:12], rd, 7'b0110111};
      OP_AUIPC:  w = {imm[31:12], rd, 7'b0010111};
      OP_JAL:    w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      OP_JALR:   w = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
      default:   w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  assign legal_s   = is_legal(op_q, alu_q, br_q);
  assign encoded_s = encode_instr(op_q, alu_q, br_q, rd_q, rs1_q, rs2_q, imm_q);

  // Session FSM, request capture, address/word-count bookkeeping and status flags.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    alu_d   = alu_q;
    br_d    = br_q;
    rd_d    = rd_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    imm_d   = imm_q;
    last_d  = last_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    error_d = error_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          op_d    = bus.op_class;
          alu_d   = bus.alu_op;
          br_d    = bus.br_type;
          rd_d    = bus.rd;
          rs1_d   = bus.rs1;
          rs2_d   = bus.rs2;
          imm_d   = bus.imm;
          last_d  = bus.last;
          state_d = S_ENCODE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ENCODE: begin
        wdata_d = encoded_s;
        if (legal_s) begin
          wr_en_d = 1'b1;
          state_d = S_WRITE;
        end else begin
          error_d = 1'b1;
          state_d = S_ERR;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + 32'd4;
        count_d = count_q + CW'(1);
        if (last_q || (count_q == CW'(DEPTH - 1))) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= 4'd0;
      alu_q      <= 4'd0;
      br_q       <= 3'd0;
      rd_q       <= 5'd0;
      rs1_q      <= 5'd0;
      rs2_q      <= 5'd0;
      imm_q      <= 32'd0;
      last_q     <= 1'b0;
      in_ready_q <= 1'b1;
      wr_en_q    <= 1'b0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= 32'd0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      alu_q      <= alu_d;
      br_q       <= br_d;
      rd_q       <= rd_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      imm_q      <= imm_d;
      last_q     <= last_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      error_q    <= error_d;
      count_q    <= count_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_wr_en = wr_en_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a default-DEPTH instance and a DEPTH=2 instance
// share the clock, reset and request payload but have separate in_valid lines.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  op_class_r = 4'd0;
  logic [3:0]  alu_op_r = 4'd0;
  logic [2:0]  br_type_r = 3'd0;
  logic [4:0]  rd_r = 5'd0;
  logic [4:0]  rs1_r = 5'd0;
  logic [4:0]  rs2_r = 5'd0;
  logic [31:0] imm_r = 32'd0;
  logic        last_r = 1'b0;
  logic        valid_a = 1'b0;
  logic        valid_b = 1'b0;

  int compared = 0;
  int mismatched = 0;

  instr_encoder_if bus_a ();
  instr_encoder_if bus_b ();

  assign bus_a.in_valid = valid_a;
  assign bus_a.op_class = op_class_r;
  assign bus_a.alu_op   = alu_op_r;
  assign bus_a.br_type  = br_type_r;
  assign bus_a.rd       = rd_r;
  assign bus_a.rs1      = rs1_r;
  assign bus_a.rs2      = rs2_r;
  assign bus_a.imm      = imm_r;
  assign bus_a.last     = last_r;

  assign bus_b.in_valid = valid_b;
  assign bus_b.op_class = op_class_r;
  assign bus_b.alu_op   = alu_op_r;
  assign bus_b.br_type  = br_type_r;
  assign bus_b.rd       = rd_r;
  assign bus_b.rs1      = rs1_r;
  assign bus_b.rs2      = rs2_r;
  assign bus_b.imm      = imm_r;
  assign bus_b.last     = last_r;

  instr_encoder #(.BASE_ADDR(32'h0), .DEPTH(256)) dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_a)
  );

  instr_encoder #(.BASE_ADDR(32'h0), .DEPTH(2)) dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Presents one request to the selected DUT and releases it right after the accepting edge.
  task automatic drive(input logic sel, input logic [3:0] op, input logic [3:0] alu,
                       input logic [2:0] br, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm, input logic last);
    int t;
    t = 0;
    @(negedge clk);
    while (!(sel ? bus_b.in_ready : bus_a.in_ready) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check("ready_timeout", 32'(t), 32'd0);
    op_class_r = op; alu_op_r = alu; br_type_r = br;
    rd_r = rd; rs1_r = rs1; rs2_r = rs2; imm_r = imm; last_r = last;
    if (sel) valid_b = 1'b1; else valid_a = 1'b1;
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  task automatic watch(input logic sel, output int n, output int idx,
                       output logic [31:0] addr, output logic [31:0] data);
    n = 0; idx = 0; addr = 32'hDEAD_BEEF; data = 32'hDEAD_BEEF;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (sel ? bus_b.imem_wr_en : bus_a.imem_wr_en) begin
        n++;
        if (n == 1) begin
          idx  = k;
          addr = sel ? bus_b.imem_addr : bus_a.imem_addr;
          data = sel ? bus_b.imem_wdata : bus_a.imem_wdata;
        end
      end
    end
  endtask

  task automatic write_req(input string tag, input logic sel, input logic [3:0] op,
                           input logic [3:0] alu, input logic [2:0] br, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                           input logic last, input logic [31:0] exp_addr,
                           input logic [31:0] exp_data);
    int n, idx;
    logic [31:0] addr, data;
    drive(sel, op, alu, br, rd, rs1, rs2, imm, last);
    watch(sel, n, idx, addr, data);
    check({tag, "_pulses"}, 32'(n), 32'd1);
    check({tag, "_latency"}, 32'(idx), 32'd2);
    check({tag, "_addr"}, addr, exp_addr);
    check({tag, "_data"}, data, exp_data);
  endtask

  task automatic illegal_req(input string tag, input logic [3:0] op, input logic [3:0] alu,
                             input logic [2:0] br);
    int n, idx;
    logic [31:0] addr, data;
    drive(1'b0, op, alu, br, 5'd1, 5'd2, 5'd3, 32'h0000_0010, 1'b0);
    watch(1'b0, n, idx, addr, data);
    check({tag, "_pulses"}, 32'(n), 32'd0);
    check({tag, "_error"}, 32'(bus_a.error), 32'd1);
    check({tag, "_ready"}, 32'(bus_a.in_ready), 32'd0);
    check({tag, "_done"}, 32'(bus_a.done), 32'd0);
  endtask

  initial begin
    int n;
    do_reset();
    @(negedge clk);
    check("rst_ready", 32'(bus_a.in_ready), 32'd1);
    check("rst_wr_en", 32'(bus_a.imem_wr_en), 32'd0);
    check("rst_addr", bus_a.imem_addr, 32'h0);
    check("rst_wdata", bus_a.imem_wdata, 32'h0);
    check("rst_done", 32'(bus_a.done), 32'd0);
    check("rst_error", 32'(bus_a.error), 32'd0);

    // Session on the default instance: one of each main format, ending with last=1.
    write_req("r_add",  1'b0, 4'd0, 4'd0, 3'd0, 5'd3,  5'd1, 5'd2, 32'h0,         1'b0, 32'h00, 32'h002081B3);
    write_req("r_sub",  1'b0, 4'd0, 4'd1, 3'd0, 5'd5,  5'd6, 5'd7, 32'h0,         1'b0, 32'h04, 32'h407302B3);
    write_req("i_add",  1'b0, 4'd1, 4'd0, 3'd0, 5'd1,  5'd0, 5'd9, 32'hFFFFFFFF,  1'b0, 32'h08, 32'hFFF00093);
    write_req("store",  1'b0, 4'd3, 4'd0, 3'd0, 5'd9,  5'd2, 5'd3, 32'h000007E5,  1'b0, 32'h0C, 32'h7E3122A3);
    write_req("i_sra",  1'b0, 4'd1, 4'd8, 3'd0, 5'd4,  5'd5, 5'd6, 32'hFFFFFFE3,  1'b0, 32'h10, 32'h4032D213);
    write_req("jal",    1'b0, 4'd7, 4'd0, 3'd0, 5'd1,  5'd0, 5'd0, 32'h00000800,  1'b0, 32'h14, 32'h001000EF);
    write_req("branch", 1'b0, 4'd4, 4'd0, 3'd0, 5'd7,  5'd1, 5'd2, 32'h00000009,  1'b0, 32'h18, 32'h00208463);
    write_req("lui",    1'b0, 4'd5, 4'd0, 3'd0, 5'd10, 5'd0, 5'd0, 32'h12345000,  1'b1, 32'h1C, 32'h12345537);
    check("done_flag", 32'(bus_a.done), 32'd1);
    check("done_ready", 32'(bus_a.in_ready), 32'd0);

    // A request held in DONE must never be taken.
    op_class_r = 4'd0; alu_op_r = 4'd0; rd_r = 5'd1; rs1_r = 5'd1; rs2_r = 5'd1;
    valid_a = 1'b1;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus_a.imem_wr_en) n++;
    end
    valid_a = 1'b0;
    check("done_hold_pulses", 32'(n), 32'd0);
    check("done_hold_flag", 32'(bus_a.done), 32'd1);

    do_reset();
    @(negedge clk);
    check("rst2_addr", bus_a.imem_addr, 32'h0);
    check("rst2_done", 32'(bus_a.done), 32'd0);
    illegal_req("bad_class", 4'd9, 4'd0, 3'd0);
    do_reset();
    illegal_req("i_sub", 4'd1, 4'd1, 3'd0);
    do_reset();
    illegal_req("bad_alu", 4'd0, 4'd10, 3'd0);
    do_reset();
    illegal_req("br_011", 4'd4, 4'd0, 3'd3);
    do_reset();

    // DEPTH=2 instance terminates the session without last.
    write_req("d2_w0", 1'b1, 4'd0, 4'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, 32'h00, 32'h002081B3);
    check("d2_not_done", 32'(bus_b.done), 32'd0);
    write_req("d2_w1", 1'b1, 4'd0, 4'd1, 3'd0, 5'd5, 5'd6, 5'd7, 32'h0, 1'b0, 32'h04, 32'h407302B3);
    check("d2_done", 32'(bus_b.done), 32'd1);
    check("d2_ready", 32'(bus_b.in_ready), 32'd0);

    // Reset while the DEPTH=2 instance is in WRITE aborts the word and clears the count.
    do_reset();
    write_req("d2_r0", 1'b1, 4'd0, 4'd0, 3'd0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, 32'h00, 32'h002081B3);
    drive(1'b1, 4'd1, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("abort_in_write", 32'(bus_b.imem_wr_en), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_no_pulse", 32'(bus_b.imem_wr_en), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_no_pulse2", 32'(bus_b.imem_wr_en), 32'd0);
    check("abort_addr", bus_b.imem_addr, 32'h0);
    check("abort_ready", 32'(bus_b.in_ready), 32'd1);
    write_req("d2_a0", 1'b1, 4'd1, 4'd0, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 32'h00, 32'hFFF00093);
    check("abort_count_cleared", 32'(bus_b.done), 32'd0);
    write_req("d2_a1", 1'b1, 4'd5, 4'd0, 3'd0, 5'd10, 5'd0, 5'd0, 32'h12345000, 1'b0, 32'h04, 32'h12345537);
    check("abort_done_after2", 32'(bus_b.done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0, byte address of the first instruction-memory word written.
REQ-002 Parameter DEPTH, default 256, maximum number of words written per load session.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  source presents one instruction request.
REQ-006 in_ready  output  1  encoder can accept a request.
REQ-007 op_class  input  4  0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI, 6 AUIPC, 7 JAL, 8 JALR; 9-15 illegal.
REQ-008 alu_op  input  4  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 slt, 8 sra, 9 sltu; used for R and I-ALU.
REQ-009 br_type  input  3  branch funct3, used for BRANCH only.
REQ-010 rd, rs1, rs2  input  5 each  register fields.
REQ-011 imm  input  32  immediate, full-width value before field slicing.
REQ-012 last  input  1  marks the final request of the session.
REQ-013 imem_wr_en  output  1  one-cycle instruction-memory write strobe.
REQ-014 imem_addr  output  32  byte write address.
REQ-015 imem_wdata  output  32  encoded RV32I instruction word.
REQ-016 done, error  output  1 each  sticky session status flags.

Function
REQ-017 The FSM SHALL have states IDLE, ENCODE, WRITE, DONE and ERR; in_ready SHALL be 1 only in IDLE.
REQ-018 A request SHALL be accepted when in_valid and in_ready are both 1; all inputs are captured into registers and the FSM moves to ENCODE.
REQ-019 ENCODE SHALL register imem_wdata and the legality check, then move to WRITE if the request is legal, else to ERR.
REQ-020 WRITE SHALL assert imem_wr_en for exactly one cycle at the current imem_addr.
  - On leaving WRITE, imem_addr advances by 4.
  - Next state: DONE if last=1 or DEPTH words have been written, else IDLE.
REQ-021 Latency SHALL be: accept at edge N, imem_wr_en high during cycle N+2; throughput is one word per 3 cycles.
REQ-022 R encoding SHALL be: opcode 0110011; funct3 add/sub 000, sll 001, slt 010, sltu 011, xor 100, srl/sra 101, or 110, and 111; funct7 0100000 for sub/sra, else 0.
REQ-023 I-ALU encoding SHALL be: opcode 0010011; same funct3 map; imm[11:0] in [31:20].
  - For sll/srl/sra: [31:25] = 0100000 for sra, else 0, and [24:20] = imm[4:0].
REQ-024 LOAD SHALL encode opcode 0000011, funct3 010, imm[11:0] in [31:20].
REQ-025 STORE SHALL encode opcode 0100011, funct3 010, imm[11:5] in [31:25] and imm[4:0] in [11:7].
REQ-026 BRANCH SHALL encode opcode 1100011, funct3 = br_type, {imm[12], imm[10:5]} in [31:25] and {imm[4:1], imm[11]} in [11:7]; imm[0] is ignored.
REQ-027 LUI and AUIPC SHALL encode opcode 0110111 / 0010111 with imm[31:12] in [31:12].
REQ-028 JAL SHALL encode opcode 1101111 with {imm[20], imm[10:1], imm[11], imm[19:12]} in [31:12].
REQ-029 JALR SHALL encode opcode 1100111, funct3 000, imm[11:0] in [31:20].
REQ-030 Unused register fields SHALL be encoded as 0 (e.g. rs2 for I-ALU, rd for STORE/BRANCH).
REQ-031 A request SHALL be illegal if any of these holds:
  - op_class > 8;
  - alu_op > 9 for R or I-ALU;
  - alu_op = 1 for I-ALU;
  - br_type 010 or 011 for BRANCH.
REQ-032 ERR SHALL hold error=1, perform no write and keep in_ready=0 until reset.
REQ-033 DONE SHALL hold done=1 and in_ready=0 until reset; in_valid is ignored in DONE and ERR.
REQ-034 in_valid asserted outside IDLE SHALL NOT be accepted; the source holds the request until accepted.

Reset
REQ-035 On a clock edge with rst_n=0, state SHALL become IDLE, imem_addr BASE_ADDR, and imem_wr_en, imem_wdata, done, error 0; in_ready reads 1 afterwards.
REQ-036 Reset in ENCODE or WRITE SHALL abort the request: no imem_wr_en pulse after the reset edge, and the word count is cleared.

Verification
REQ-037 R add, rd=3 rs1=1 rs2=2 -> imem_wdata 0x002081B3 at imem_addr 0x0, wr_en one cycle at N+2; a second request writes at 0x4.
REQ-038 R sub, rd=5 rs1=6 rs2=7 -> 0x407302B3; I-ALU add, rd=1 rs1=0 imm=0xFFFFFFFF -> 0xFFF00093.
REQ-039 BRANCH br_type=000, rs1=1 rs2=2 imm=8 -> 0x00208463; LUI rd=10 imm=0x12345000 with last=1 -> 0x12345537, then done=1 and in_ready=0.
REQ-040 op_class=9, then I-ALU with alu_op=1 after reset -> error=1 each time, no wr_en pulse, in_ready stays 0.
REQ-041 DEPTH=2 without last -> two writes at 0x0 and 0x4, then done=1; reset asserted during WRITE -> no pulse, imem_addr=0x0, in_ready=1.
